// File: rtl/gemm_tile_sequencer_if.sv
// Job/tile interface of the GEMM tile sequencer.
//
// Handshake semantics (both the start and the tile channel): a transfer
// happens on a rising clk edge where valid and ready are both high. A source
// holding valid high keeps its payload stable until that transfer. A sink may
// raise or lower ready at any time. Valid never depends combinationally on
// ready.
interface gemm_tile_sequencer_if #(
    parameter int DIM_W = 5
);
    // Job request channel
    logic             start_valid;
    logic             start_ready;
    logic [DIM_W-1:0] ksize;
    logic [DIM_W-1:0] nsize;

    // Dataflow mode and operand mux selects
    logic [1:0]       mode;
    logic             if_mux_sel;
    logic             w_mux_sel;

    // Tile descriptor channel
    logic             tile_valid;
    logic             tile_ready;
    logic [DIM_W-1:0] tile_k_off;
    logic [DIM_W-1:0] tile_n_off;
    logic [DIM_W-1:0] tile_k_len;
    logic [DIM_W-1:0] tile_n_len;
    logic             tile_last;

    // Status
    logic             busy;
    logic             done;
    logic             cfg_err;

    // Command front-end / tile consumer side
    modport master (
        output start_valid, ksize, nsize, tile_ready,
        input  start_ready, mode, if_mux_sel, w_mux_sel,
        input  tile_valid, tile_k_off, tile_n_off, tile_k_len, tile_n_len, tile_last,
        input  busy, done, cfg_err
    );

    // Sequencer side
    modport slave (
        input  start_valid, ksize, nsize, tile_ready,
        output start_ready, mode, if_mux_sel, w_mux_sel,
        output tile_valid, tile_k_off, tile_n_off, tile_k_len, tile_n_len, tile_last,
        output busy, done, cfg_err
    );
endinterface

// File: rtl/gemm_tile_sequencer.sv
// GEMM tile sequencer: accepts a (ksize, nsize) job, classifies it into one of
// four dataflow modes, drives the IF/W operand mux selects and walks the job
// as SYS_ROWS x SYS_COLS tiles (K inner loop, N outer loop) over a
// valid/ready tile stream. Every output comes straight from a flop.
module gemm_tile_sequencer #(
    parameter int DIM_W    = 5,
    parameter int SYS_ROWS = 8,
    parameter int SYS_COLS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    gemm_tile_sequencer_if.slave        bus,
    output logic [1:0]                  state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Offset arithmetic is one bit wider than DIM_W so stepping past a size
    // near 2^DIM_W-1 cannot wrap back into range.
    localparam logic [DIM_W:0]   ROWS_X = (DIM_W+1)'(SYS_ROWS);
    localparam logic [DIM_W:0]   COLS_X = (DIM_W+1)'(SYS_COLS);
    localparam logic [DIM_W-1:0] ROWS_N = DIM_W'(SYS_ROWS);
    localparam logic [DIM_W-1:0] COLS_N = DIM_W'(SYS_COLS);

    state_t state_q, state_d;

    // Latched job
    logic [DIM_W-1:0] ksize_q, nsize_q;

    // Position of the next tile to load into the descriptor registers
    logic [DIM_W:0]   k_cnt_q, n_cnt_q;

    // Registered outputs
    logic             start_ready_q;
    logic [1:0]       mode_q;
    logic             if_sel_q, w_sel_q;
    logic             tile_valid_q;
    logic [DIM_W-1:0] tile_k_off_q, tile_n_off_q, tile_k_len_q, tile_n_len_q;
    logic             tile_last_q;
    logic             busy_q, done_q, cfg_err_q;

    // Combinational helpers
    logic             start_hs;
    logic             size_zero;
    logic             tile_hs;
    logic             tile_load;
    logic             tall, wide;
    logic [DIM_W:0]   k_ext, n_ext;
    logic [DIM_W:0]   k_rem, n_rem;
    logic [DIM_W-1:0] k_len, n_len;
    logic             k_last, n_last;

    assign start_hs  = bus.start_valid & start_ready_q;
    assign size_zero = (bus.ksize == '0) | (bus.nsize == '0);
    assign tile_hs   = tile_valid_q & bus.tile_ready;

    // The descriptor register is refilled when it is empty (first tile of a
    // job) or when its current, non-final tile is being accepted, so tiles go
    // out back to back with no bubble.
    assign tile_load = (state_q == ST_ISSUE) &
                       (~tile_valid_q | (bus.tile_ready & ~tile_last_q));

    // Tallwave: K fits in one array height. Widewave: N spans several widths.
    assign tall = ({1'b0, ksize_q} <= ROWS_X);
    assign wide = ({1'b0, nsize_q} >  COLS_X);

    // Descriptor of the tile at (k_cnt_q, n_cnt_q) within the latched job
    always_comb begin
        k_ext  = {1'b0, ksize_q};
        n_ext  = {1'b0, nsize_q};
        k_rem  = k_ext - k_cnt_q;
        n_rem  = n_ext - n_cnt_q;
        k_len  = (k_rem > ROWS_X) ? ROWS_N : k_rem[DIM_W-1:0];
        n_len  = (n_rem > COLS_X) ? COLS_N : n_rem[DIM_W-1:0];
        k_last = ((k_cnt_q + ROWS_X) >= k_ext);
        n_last = ((n_cnt_q + COLS_X) >= n_ext);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; zero-size jobs are refused without leaving IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_hs && !size_zero) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (tile_hs && tile_last_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Job latch: sizes are captured only on an accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            ksize_q <= '0;
            nsize_q <= '0;
        end else if (start_hs) begin
            ksize_q <= bus.ksize;
            nsize_q <= bus.nsize;
        end
    end

    // Mode and selects: written in DECODE only, held through IDLE afterwards
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= 2'b00;
            if_sel_q <= 1'b0;
            w_sel_q  <= 1'b0;
        end else if (state_q == ST_DECODE) begin
            mode_q   <= {tall, ~wide};
            if_sel_q <= ~tall;
            w_sel_q  <= tall;
        end
    end

    // Tile walker: K inner loop, N outer loop; descriptor held while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            k_cnt_q      <= '0;
            n_cnt_q      <= '0;
            tile_valid_q <= 1'b0;
            tile_k_off_q <= '0;
            tile_n_off_q <= '0;
            tile_k_len_q <= '0;
            tile_n_len_q <= '0;
            tile_last_q  <= 1'b0;
        end else if (state_q == ST_DECODE) begin
            k_cnt_q      <= '0;
            n_cnt_q      <= '0;
        end else if (tile_load) begin
            tile_valid_q <= 1'b1;
            tile_k_off_q <= k_cnt_q[DIM_W-1:0];
            tile_n_off_q <= n_cnt_q[DIM_W-1:0];
            tile_k_len_q <= k_len;
            tile_n_len_q <= n_len;
            tile_last_q  <= k_last & n_last;
            if (k_last) begin
                k_cnt_q <= '0;
                n_cnt_q <= n_cnt_q + COLS_X;
            end else begin
                k_cnt_q <= k_cnt_q + ROWS_X;
            end
        end else if (tile_hs) begin
            // Final tile accepted: the stream goes quiet for the DONE cycle
            tile_valid_q <= 1'b0;
        end
    end

    // Status flags registered from the next state so they align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            start_ready_q <= (state_d == ST_IDLE);
            busy_q        <= (state_d != ST_IDLE);
            done_q        <= (state_d == ST_DONE);
            cfg_err_q     <= start_hs & size_zero;
        end
    end

    assign bus.start_ready = start_ready_q;
    assign bus.mode        = mode_q;
    assign bus.if_mux_sel  = if_sel_q;
    assign bus.w_mux_sel   = w_sel_q;
    assign bus.tile_valid  = tile_valid_q;
    assign bus.tile_k_off  = tile_k_off_q;
    assign bus.tile_n_off  = tile_n_off_q;
    assign bus.tile_k_len  = tile_k_len_q;
    assign bus.tile_n_len  = tile_n_len_q;
    assign bus.tile_last   = tile_last_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.cfg_err     = cfg_err_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Bench for gemm_tile_sequencer (DIM_W=5, SYS_ROWS=SYS_COLS=8).
module tb_gemm_tile_sequencer;

  logic clk;
  logic rst;
  logic [1:0] state_dbg;

  gemm_tile_sequencer_if #(.DIM_W(5)) bus ();

  gemm_tile_sequencer #(
    .DIM_W   (5),
    .SYS_ROWS(8),
    .SYS_COLS(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // descriptor = {k_off, n_off, k_len, n_len, last}
  logic [20:0] exp_q[$];
  logic [1:0]  cur_mode = 2'b00;
  int          ready_mode = 0;   // 0: always ready, 1: random, 2: held low
  bit          done_due = 1'b0;
  logic [20:0] mon_exp;
  logic [20:0] mon_got;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- tile_ready driver ----------------
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       bus.tile_ready = 1'b1;
      1:       bus.tile_ready = ($urandom_range(0, 3) != 0);
      default: bus.tile_ready = 1'b0;
    endcase
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (done_due) begin
        check("done_after_last", 32'(bus.done), 1);
        done_due = 1'b0;
      end
      if (bus.tile_valid && bus.tile_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_tile", 32'(bus.tile_valid), 0);
        end else begin
          mon_exp = exp_q.pop_front();
          mon_got = {bus.tile_k_off, bus.tile_n_off, bus.tile_k_len, bus.tile_n_len, bus.tile_last};
          check("tile_desc", 32'(mon_got), 32'(mon_exp));
          check("tile_mode", 32'(bus.mode), 32'(cur_mode));
          if (mon_exp[0]) done_due = 1'b1;
        end
      end
    end
  end

  // ---------------- model / driver tasks ----------------
  task automatic push_tiles(input int k, input int n);
    int kl, nl;
    bit last;
    for (int no = 0; no < n; no += 8) begin
      for (int ko = 0; ko < k; ko += 8) begin
        kl   = (k - ko < 8) ? (k - ko) : 8;
        nl   = (n - no < 8) ? (n - no) : 8;
        last = (ko + 8 >= k) && (no + 8 >= n);
        exp_q.push_back({ko[4:0], no[4:0], kl[4:0], nl[4:0], last});
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mode"},        32'(bus.mode), 0);
    check({tag, "_if_sel"},      32'(bus.if_mux_sel), 0);
    check({tag, "_w_sel"},       32'(bus.w_mux_sel), 0);
    check({tag, "_tile_valid"},  32'(bus.tile_valid), 0);
    check({tag, "_tile_fields"}, 32'({bus.tile_k_off, bus.tile_n_off, bus.tile_k_len,
                                      bus.tile_n_len, bus.tile_last}), 0);
    check({tag, "_busy"},        32'(bus.busy), 0);
    check({tag, "_done"},        32'(bus.done), 0);
    check({tag, "_cfg_err"},     32'(bus.cfg_err), 0);
    check({tag, "_start_ready"}, 32'(bus.start_ready), 1);
    check({tag, "_state"},       32'(state_dbg), 0);
  endtask

  // Drives one accepted job and checks decode latency; returns at the
  // negedge where the first tile is first visible.
  task automatic start_job(input int k, input int n);
    logic [1:0] em;
    bit tall, wide;
    tall = (k <= 8);
    wide = (n > 8);
    if (!tall && wide)       em = 2'b00;
    else if (!tall && !wide) em = 2'b01;
    else if (tall && wide)   em = 2'b10;
    else                     em = 2'b11;
    @(posedge clk); #1;
    check("start_ready_idle", 32'(bus.start_ready), 1);
    push_tiles(k, n);
    bus.start_valid = 1'b1;
    bus.ksize = k[4:0];
    bus.nsize = n[4:0];
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    cur_mode = em;
    @(negedge clk);
    check("lat_busy",        32'(bus.busy), 1);
    check("lat_start_ready", 32'(bus.start_ready), 0);
    check("lat_tv_t1",       32'(bus.tile_valid), 0);
    @(negedge clk);
    check("lat_mode",        32'(bus.mode), 32'(em));
    check("lat_if_sel",      32'(bus.if_mux_sel), 32'(!tall));
    check("lat_w_sel",       32'(bus.w_mux_sel), 32'(tall));
    check("lat_tv_t2",       32'(bus.tile_valid), 0);
    @(negedge clk);
    check("lat_tile_valid",  32'(bus.tile_valid), 1);
  endtask

  task automatic wait_done(input int budget);
    int  c;
    bit  seen;
    c = 0;
    seen = 1'b0;
    while (c < budget && !seen) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      c++;
    end
    check("done_seen", 32'(seen), 1);
    if (seen) begin
      check("q_empty_at_done",  exp_q.size(), 0);
      check("busy_in_done",     32'(bus.busy), 1);
      check("tv_low_in_done",   32'(bus.tile_valid), 0);
      @(negedge clk);
      check("done_one_cycle",   32'(bus.done), 0);
      check("idle_busy",        32'(bus.busy), 0);
      check("idle_start_ready", 32'(bus.start_ready), 1);
    end
  endtask

  task automatic zero_job(input int k, input int n);
    @(posedge clk); #1;
    bus.start_valid = 1'b1;
    bus.ksize = k[4:0];
    bus.nsize = n[4:0];
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    @(negedge clk);
    check("zero_cfg_err",     32'(bus.cfg_err), 1);
    check("zero_start_ready", 32'(bus.start_ready), 1);
    check("zero_busy",        32'(bus.busy), 0);
    check("zero_mode_kept",   32'(bus.mode), 32'(cur_mode));
    repeat (4) begin
      @(negedge clk);
      check("zero_cfg_err_drop", 32'(bus.cfg_err), 0);
      check("zero_no_tile",      32'(bus.tile_valid), 0);
      check("zero_no_done",      32'(bus.done), 0);
      check("zero_ready_held",   32'(bus.start_ready), 1);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int rk, rn;
    rst = 1'b1;
    bus.start_valid = 1'b0;
    bus.ksize = '0;
    bus.nsize = '0;
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals("rst");

    // 20x20: mode 00, 9 tiles
    start_job(20, 20);
    wait_done(200);

    // 8x8: mode 11, single tile
    start_job(8, 8);
    wait_done(200);

    // 8x9: mode 10, two N tiles; 9x8: mode 01, two K tiles
    start_job(8, 9);
    wait_done(200);
    start_job(9, 8);
    wait_done(200);

    // zero-size jobs
    zero_job(0, 5);
    zero_job(7, 0);

    // stall on tile 2 with start pulses ignored while busy
    ready_mode = 0;
    start_job(20, 20);
    @(posedge clk); #1;
    ready_mode = 2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid",       32'(bus.tile_valid), 1);
      check("stall_k_off",       32'(bus.tile_k_off), 8);
      check("stall_n_off",       32'(bus.tile_n_off), 0);
      check("stall_k_len",       32'(bus.tile_k_len), 8);
      check("stall_n_len",       32'(bus.tile_n_len), 8);
      check("stall_last",        32'(bus.tile_last), 0);
      check("stall_start_ready", 32'(bus.start_ready), 0);
      @(posedge clk); #1;
      bus.start_valid = (i < 2);
      bus.ksize = 5'd3;
      bus.nsize = 5'd3;
    end
    ready_mode = 0;
    wait_done(200);
    repeat (4) begin
      @(negedge clk);
      check("no_ghost_job", 32'(bus.busy), 0);
    end

    // reset in the middle of ISSUE
    start_job(20, 20);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    done_due = 1'b0;
    cur_mode = 2'b00;
    @(negedge clk);
    check_reset_vals("midrst");
    start_job(8, 8);
    wait_done(200);

    // boundary and random jobs with random back-pressure
    ready_mode = 1;
    for (int j = 0; j < 8; j++) begin
      if (j == 0) begin
        rk = 31; rn = 31;
      end else if (j == 1) begin
        rk = 1; rn = 1;
      end else begin
        rk = $urandom_range(1, 31);
        rn = $urandom_range(1, 31);
      end
      start_job(rk, rn);
      wait_done(400);
    end
    ready_mode = 0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
